// File: rtl/dmem_sized.sv
// dmem_sized: byte/half/word data memory with power-up clear sequence and alignment checking
module dmem_sized #(
  parameter int ADDR_W = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              busy,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, widx;
  logic rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem [DEPTH];
  logic acc, mis, st, ld;
  logic [3:0] be;
  logic [31:0] word, sh, wd, mask, ld_val;
  logic [15:0] h;
  assign ready = state_q == RUN && !rst;
  assign busy = state_q == CLEAR;
  assign rvalid = rvalid_q;
  assign err = err_q;
  assign rdata = rdata_q;
  assign dbg_data = mem[dbg_addr];
  assign widx = addr[ADDR_W+1:2];
  assign word = mem[widx];
  // decode the request: alignment, lane enables, store merge and load extraction
  always_comb begin
    acc = req && ready;
    mis = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    st = acc && !mis && we;
    ld = acc && !mis && !we;
    be = size == 2'b00 ? 4'b0001 << addr[1:0] : size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    sh = word >> {addr[1:0], 3'b000};
    h = addr[1] ? word[31:16] : word[15:0];
    ld_val = size == 2'b00 ? {{24{sh[7] & ~uns}}, sh[7:0]} : size == 2'b01 ? {{16{h[15] & ~uns}}, h} : word;
    state_d = state_q == CLEAR && cnt_q == {ADDR_W{1'b1}} ? RUN : state_q;
    cnt_d = state_q == CLEAR ? cnt_q + 1'b1 : cnt_q;
    rvalid_d = ld;
    err_d = acc && mis;
    rdata_d = ld ? ld_val : rdata_q;
  end
  // control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      cnt_q <= '0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  // storage: zero one word per cycle while clearing, else merge the addressed lanes of a store
  always_ff @(posedge clk) begin
    if (!rst && state_q == CLEAR) mem[cnt_q] <= '0;
    else if (st) mem[widx] <= (word & ~mask) | (wd & mask);
  end
endmodule
